// File: rtl/conv_a2_unit_controller.sv
// conv_a2_unit_controller: pass sequencer for one ConvA2 unit; define CONV_A2_CTRL_STALL_EN to add a stall input
module conv_a2_unit_controller #(
   parameter int IFM_SIZE          = 14,
   parameter int IFM_DEPTH         = 6,
   parameter int KERNAL_SIZE       = 5,
   parameter int NUMBER_OF_FILTERS = 16,
   parameter int NUMBER_OF_UNITS   = 3,
   parameter int CONV_LATENCY      = 3,
   parameter int ADDRESS_BITS      = 15,
   localparam int FILT_BITS        = $clog2(NUMBER_OF_FILTERS)
) (
   input  logic                    clk,
   input  logic                    reset,
`ifdef CONV_A2_CTRL_STALL_EN
   input  logic                    stall,
`endif
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    wm_enable_read,
   output logic [ADDRESS_BITS-1:0] wm_address,
   output logic                    wm_fifo_enable,
   output logic                    ifm_read_enable,
   output logic [ADDRESS_BITS-1:0] ifm_address,
   output logic                    fifo_enable,
   output logic                    conv_enable,
   output logic                    out_valid,
   output logic [ADDRESS_BITS-1:0] out_address,
   output logic [FILT_BITS-1:0]    out_filter,
   output logic                    out_accumulate
);
   localparam int CH_PER_UNIT = IFM_DEPTH / NUMBER_OF_UNITS;
   localparam int NUM_PIX     = IFM_SIZE * IFM_SIZE;
   localparam int NUM_W       = KERNAL_SIZE * KERNAL_SIZE;
   localparam int DRAIN_LEN   = 2 + CONV_LATENCY;
   localparam int K_BITS      = $clog2(NUM_W);
   localparam int T_BITS      = $clog2(NUM_PIX);
   localparam int RC_BITS     = $clog2(IFM_SIZE);
   localparam int CH_BITS     = CH_PER_UNIT > 1 ? $clog2(CH_PER_UNIT) : 1;
   localparam int D_BITS      = $clog2(DRAIN_LEN);

   typedef enum logic [2:0] {IDLE, LOAD_W, W_FLUSH, STREAM, DRAIN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [FILT_BITS-1:0]    f_q, f_d;
   logic [CH_BITS-1:0]      ch_q, ch_d;
   logic [K_BITS-1:0]       k_q, k_d;
   logic [T_BITS-1:0]       t_q, t_d;
   logic [RC_BITS-1:0]      r_q, r_d, c_q, c_d;
   logic [D_BITS-1:0]       dr_q, dr_d;
   logic                    wm_fifo_enable_q, wm_fifo_enable_d;
   logic                    fifo_enable_q, fifo_enable_d;
   logic [1:0]              win_q, win_d;
   logic [CONV_LATENCY-1:0] vld_q, vld_d;
   logic [ADDRESS_BITS-1:0] oa_q, oa_d;
   logic                    stl, window;
   logic                    k_last, t_last, c_last, dr_last, ch_last, f_last;

`ifdef CONV_A2_CTRL_STALL_EN
   assign stl = stall;
`else
   assign stl = 1'b0;
`endif

   assign k_last  = k_q == K_BITS'(NUM_W - 1);
   assign t_last  = t_q == T_BITS'(NUM_PIX - 1);
   assign c_last  = c_q == RC_BITS'(IFM_SIZE - 1);
   assign dr_last = dr_q == D_BITS'(DRAIN_LEN - 1);
   assign ch_last = ch_q == CH_BITS'(CH_PER_UNIT - 1);
   assign f_last  = f_q == FILT_BITS'(NUMBER_OF_FILTERS - 1);

   assign busy            = state_q != IDLE;
   assign done            = state_q == DONE;
   assign wm_enable_read  = state_q == LOAD_W && !stl;
   assign ifm_read_enable = state_q == STREAM && !stl;
   assign wm_address      = ADDRESS_BITS'((32'(f_q) * CH_PER_UNIT + 32'(ch_q)) * NUM_W + 32'(k_q));
   assign ifm_address     = ADDRESS_BITS'(32'(ch_q) * NUM_PIX + 32'(t_q));
   // a window is complete once KERNAL_SIZE-1 fresh rows and columns have streamed in
   assign window          = ifm_read_enable && r_q >= RC_BITS'(KERNAL_SIZE - 1) && c_q >= RC_BITS'(KERNAL_SIZE - 1);
   assign wm_fifo_enable  = wm_fifo_enable_q;
   assign fifo_enable     = fifo_enable_q;
   assign conv_enable     = win_q[1];
   assign out_valid       = vld_q[CONV_LATENCY-1];
   assign out_address     = oa_q;
   // f and ch only change at the end of DRAIN, after the last output of the pass
   assign out_filter      = f_q;
   assign out_accumulate  = ch_q != '0;

   // pass sequencing: next state and loop counters
   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      ch_d    = ch_q;
      k_d     = k_q;
      t_d     = t_q;
      r_d     = r_q;
      c_d     = c_q;
      dr_d    = dr_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD_W;
            f_d     = '0;
            ch_d    = '0;
            k_d     = '0;
         end
         LOAD_W: if (!stl) begin
            k_d     = k_last ? '0 : k_q + 1'b1;
            state_d = k_last ? W_FLUSH : LOAD_W;
         end
         W_FLUSH: begin
            state_d = STREAM;
            t_d     = '0;
            r_d     = '0;
            c_d     = '0;
         end
         STREAM: if (!stl) begin
            t_d     = t_q + 1'b1;
            c_d     = c_last ? '0 : c_q + 1'b1;
            r_d     = c_last ? r_q + 1'b1 : r_q;
            state_d = t_last ? DRAIN : STREAM;
            dr_d    = '0;
         end
         DRAIN: begin
            dr_d = dr_q + 1'b1;
            if (dr_last) begin
               k_d     = '0;
               state_d = ch_last && f_last ? DONE : LOAD_W;
               ch_d    = ch_last ? '0 : ch_q + 1'b1;
               f_d     = ch_last && !f_last ? f_q + 1'b1 : f_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            f_d     = '0;
            ch_d    = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // delay pipelines: FIFO pushes, window enable and output tag counter
   always_comb begin
      wm_fifo_enable_d = wm_enable_read;
      fifo_enable_d    = ifm_read_enable;
      win_d            = {win_q[0], window};
      vld_d            = (vld_q << 1) | CONV_LATENCY'(conv_enable);
      oa_d             = state_q == LOAD_W ? '0 : oa_q + ADDRESS_BITS'(out_valid);
   end

   // state and pipeline registers, cleared asynchronously so nothing stale leaks after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         f_q              <= '0;
         ch_q             <= '0;
         k_q              <= '0;
         t_q              <= '0;
         r_q              <= '0;
         c_q              <= '0;
         dr_q             <= '0;
         wm_fifo_enable_q <= 1'b0;
         fifo_enable_q    <= 1'b0;
         win_q            <= '0;
         vld_q            <= '0;
         oa_q             <= '0;
      end else begin
         state_q          <= state_d;
         f_q              <= f_d;
         ch_q             <= ch_d;
         k_q              <= k_d;
         t_q              <= t_d;
         r_q              <= r_d;
         c_q              <= c_d;
         dr_q             <= dr_d;
         wm_fifo_enable_q <= wm_fifo_enable_d;
         fifo_enable_q    <= fifo_enable_d;
         win_q            <= win_d;
         vld_q            <= vld_d;
         oa_q             <= oa_d;
      end
   end
endmodule

// File: tb/tb_conv_a2_unit_controller.sv
// tb_conv_a2_unit_controller: directed self-checking bench for the ConvA2 unit sequencer
module tb_conv_a2_unit_controller;
   localparam int PL = 227;
   localparam int LAYER = 32 * PL + 1;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic        busy, done, wm_enable_read, wm_fifo_enable, ifm_read_enable, fifo_enable;
   logic        conv_enable, out_valid, out_accumulate;
   logic [14:0] wm_address, ifm_address, out_address;
   logic [3:0]  out_filter;
`ifdef CONV_A2_CTRL_STALL_EN
   logic        stall = 1'b0;
`endif
   int n_chk = 0, n_fail = 0;

   conv_a2_unit_controller dut (
      .clk(clk), .reset(reset),
`ifdef CONV_A2_CTRL_STALL_EN
      .stall(stall),
`endif
      .start(start), .busy(busy), .done(done),
      .wm_enable_read(wm_enable_read), .wm_address(wm_address), .wm_fifo_enable(wm_fifo_enable),
      .ifm_read_enable(ifm_read_enable), .ifm_address(ifm_address), .fifo_enable(fifo_enable),
      .conv_enable(conv_enable), .out_valid(out_valid), .out_address(out_address),
      .out_filter(out_filter), .out_accumulate(out_accumulate)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic win(input logic [14:0] a);
      int p;
      p = int'(a) % 196;
      return (p / 14 >= 4) && (p % 14 >= 4);
   endfunction

   // full layer with stray start pulses; every output is compared with an address-based model
   task automatic run_layer;
      int conv_p[32], out_p[32], wm_base[32], ifm_base[32], filt_f[32], acc_f[32];
      int p, n_done = 0, done_cyc = 0, busy1 = 0, busy_err = 0, wfe_err = 0, ffe_err = 0;
      int conv_err = 0, ov_err = 0, oa_err = 0, tag_err = 0, wseq_err = 0, wcnt0 = 0;
      int first_conv = -1, a60 = -1, bad_cnt = 0, bad_base = 0;
      logic wrd1 = 0, ird1 = 0, ird2 = 0, c1 = 0, c2 = 0, c3 = 0;
      logic [14:0] ia1 = 0, ia2 = 0;
      foreach (conv_p[i]) begin
         conv_p[i] = 0; out_p[i] = 0; wm_base[i] = -1; ifm_base[i] = -1; filt_f[i] = -1; acc_f[i] = -1;
      end
      start = 1'b1;
      tick;
      for (int cyc = 1; cyc <= LAYER + 10; cyc++) begin
         start = (cyc == 50 || cyc == 3000 || cyc == 7000);
         p = (cyc - 1) / PL;
         if (p > 31) p = 31;
         if (cyc == 1) busy1 = busy;
         if (cyc <= LAYER && !busy) busy_err++;
         if (wm_fifo_enable !== wrd1) wfe_err++;
         if (fifo_enable !== ird1) ffe_err++;
         if (conv_enable !== (ird2 && win(ia2))) conv_err++;
         if (out_valid !== c3) ov_err++;
         if (wm_enable_read) begin
            if (wm_base[p] < 0) wm_base[p] = wm_address;
            if (p == 0) begin
               if (wm_address !== 15'(wcnt0)) wseq_err++;
               wcnt0++;
            end
         end
         if (ifm_read_enable) begin
            if (ifm_base[p] < 0) ifm_base[p] = ifm_address;
            if (p == 0 && ifm_address == 60) a60 = cyc;
         end
         if (conv_enable) begin
            conv_p[p]++;
            if (first_conv < 0) first_conv = cyc;
         end
         if (out_valid) begin
            if (out_address !== 15'(out_p[p])) oa_err++;
            if (out_filter !== 4'(p / 2) || out_accumulate !== 1'(p % 2)) tag_err++;
            if (filt_f[p] < 0) begin filt_f[p] = out_filter; acc_f[p] = out_accumulate; end
            out_p[p]++;
         end
         if (done) begin n_done++; done_cyc = cyc; end
         ird2 = ird1; ia2 = ia1; ird1 = ifm_read_enable; ia1 = ifm_address;
         wrd1 = wm_enable_read; c3 = c2; c2 = c1; c1 = conv_enable;
         tick;
      end
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (conv_p[i] != 100 || out_p[i] != 100) bad_cnt++;
         if (wm_base[i] != i * 25 || ifm_base[i] != (i % 2) * 196) bad_base++;
      end
      check("busy_after_start", busy1, 1);
      check("wm_addr_first", wm_base[0], 0);
      check("wm_reads_pass0", wcnt0, 25);
      check("wm_addr_seq", wseq_err, 0);
      check("wm_fifo_align", wfe_err, 0);
      check("ifm_fifo_align", ffe_err, 0);
      check("conv_window_model", conv_err, 0);
      check("out_valid_delay", ov_err, 0);
      check("conv_pass0", conv_p[0], 100);
      check("out_pass0", out_p[0], 100);
      check("pass_counts_bad", bad_cnt, 0);
      check("window_first_lag", first_conv - a60, 2);
      check("out_addr_seq", oa_err, 0);
      check("p1_wm_base", wm_base[1], 25);
      check("p1_ifm_base", ifm_base[1], 196);
      check("p1_accumulate", acc_f[1], 1);
      check("p2_wm_base", wm_base[2], 50);
      check("p2_filter", filt_f[2], 1);
      check("p2_accumulate", acc_f[2], 0);
      check("pass_bases_bad", bad_base, 0);
      check("tag_err", tag_err, 0);
      check("busy_err", busy_err, 0);
      check("done_cycle", done_cyc, LAYER);
      check("done_count", n_done, 1);
      check("idle_after_done", busy, 0);
   endtask

   // asynchronous reset in the middle of STREAM, quiet window after release, then a clean pass
   task automatic reset_test;
      logic [7:0] quiet = '0;
      int n_wr = 0, n_conv = 0, n_out = 0, oa_err = 0, first_wm = -1;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (99) tick;
      check("busy_before_reset", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_ctrl", {busy, done, wm_enable_read, wm_fifo_enable, ifm_read_enable, fifo_enable, conv_enable, out_valid}, 0);
      check("async_reset_addr", {wm_address, ifm_address}, 0);
      check("async_reset_tags", {out_address, out_filter, out_accumulate}, 0);
      repeat (2) tick;
      reset = 1'b0;
      repeat (5) begin
         tick;
         quiet |= {busy, done, wm_enable_read, wm_fifo_enable, ifm_read_enable, fifo_enable, conv_enable, out_valid};
      end
      check("post_reset_quiet", quiet, 0);
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int cyc = 1; cyc <= PL; cyc++) begin
         if (wm_enable_read) begin
            if (first_wm < 0) first_wm = wm_address;
            n_wr++;
         end
         if (conv_enable) n_conv++;
         if (out_valid) begin
            if (out_address !== 15'(n_out)) oa_err++;
            n_out++;
         end
         tick;
      end
      check("clean_wm_first", first_wm, 0);
      check("clean_wm_reads", n_wr, 25);
      check("clean_conv", n_conv, 100);
      check("clean_out", n_out, 100);
      check("clean_out_addr", oa_err, 0);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;
   endtask

`ifdef CONV_A2_CTRL_STALL_EN
   // ten stalled cycles starting at pixel 100 of the first pass
   task automatic stall_test;
      int scnt = 0, n_out = 0, oa_err = 0, rd_stalled = 0, p2_start = -1;
      start = 1'b1;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         tick;
         start = 1'b0;
         stall = scnt > 0;
         if (scnt > 0) scnt--;
         #1;
         if (stall && ifm_read_enable) rd_stalled++;
         if (out_valid && cyc <= 2 * PL) begin
            if (out_address !== 15'(n_out)) oa_err++;
            n_out++;
         end
         if (wm_enable_read && wm_address == 25 && p2_start < 0) p2_start = cyc;
         if (ifm_read_enable && ifm_address == 99) scnt = 10;
      end
      stall = 1'b0;
      check("stall_no_reads", rd_stalled, 0);
      check("stall_pass_len", p2_start, PL + 1 + 10);
      check("stall_out_count", n_out, 100);
      check("stall_out_addr", oa_err, 0);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;
   endtask
`endif

   initial begin
      repeat (3) tick;
      check("reset_ctrl", {busy, done, wm_enable_read, wm_fifo_enable, ifm_read_enable, fifo_enable, conv_enable, out_valid}, 0);
      check("reset_addr", {wm_address, ifm_address}, 0);
      check("reset_tags", {out_address, out_filter, out_accumulate}, 0);
      reset = 1'b0;
      tick;
      run_layer;
      reset_test;
`ifdef CONV_A2_CTRL_STALL_EN
      stall_test;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
